// File: rtl/elliptic_curve_structs.sv
// Shared point type and prime-field helpers for the MSM datapath.
// Short-Weierstrass curve y^2 = x^3 + b (a = 0) over GF(P_MOD); infinity is flagged, not encoded in x/y.
package elliptic_curve_structs;

  localparam int FW = 16;
  localparam logic [FW-1:0] P_MOD = 16'd65521;

  typedef struct packed {
    logic          inf;
    logic [FW-1:0] x;
    logic [FW-1:0] y;
  } curve_point_t;

  localparam curve_point_t inf_point = '{inf: 1'b1, x: '0, y: '0};

  function automatic logic point_eq(input curve_point_t a, input curve_point_t b);
    return (a.inf == b.inf) && (a.x == b.x) && (a.y == b.y);
  endfunction

  function automatic logic [FW-1:0] sub_mod(input logic [FW-1:0] a, input logic [FW-1:0] b);
    logic [FW:0] t;
    if (a >= b) t = {1'b0, a} - {1'b0, b};
    else        t = {1'b0, a} + {1'b0, P_MOD} - {1'b0, b};
    return t[FW-1:0];
  endfunction

  function automatic logic [FW-1:0] mul_mod(input logic [FW-1:0] a, input logic [FW-1:0] b);
    logic [2*FW-1:0] t;
    t = {{FW{1'b0}}, a} * {{FW{1'b0}}, b};
    t = t % {{FW{1'b0}}, P_MOD};
    return t[FW-1:0];
  endfunction

endpackage

// File: rtl/point_add.sv
// Multi-cycle affine point adder for distinct points; Reset (sync, active-high) captures P and Q and restarts.
// The slope inverse is dx^(P_MOD-2), one square-and-multiply step per cycle.
module point_add
  import elliptic_curve_structs::*;
(
  input  logic         clk,
  input  logic         Reset,
  input  curve_point_t P,
  input  curve_point_t Q,
  output curve_point_t R,
  output logic         Done
);

  typedef enum logic [1:0] {INV, LAM, OUT, FIN} phase_t;

  phase_t        phase;
  curve_point_t  p_r;
  curve_point_t  q_r;
  logic [FW-1:0] base;
  logic [FW-1:0] res;
  logic [FW-1:0] exp_bits;
  logic [FW-1:0] lam;
  logic [FW-1:0] x3;
  logic [FW-1:0] y3;

  always_comb begin
    x3 = sub_mod(sub_mod(mul_mod(lam, lam), p_r.x), q_r.x);
    y3 = sub_mod(mul_mod(lam, sub_mod(p_r.x, x3)), p_r.y);
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      p_r      <= P;
      q_r      <= Q;
      base     <= sub_mod(Q.x, P.x);
      res      <= FW'(1);
      exp_bits <= P_MOD - FW'(2);
      lam      <= '0;
      phase    <= INV;
      Done     <= 1'b0;
      R        <= inf_point;
    end else begin
      case (phase)
        INV: begin
          if (exp_bits[0]) res <= mul_mod(res, base);
          base     <= mul_mod(base, base);
          exp_bits <= exp_bits >> 1;
          if (exp_bits == FW'(1)) phase <= LAM;
        end
        LAM: begin
          lam   <= mul_mod(sub_mod(q_r.y, p_r.y), res);
          phase <= OUT;
        end
        OUT: begin
          if (p_r.inf)                R <= q_r;
          else if (q_r.inf)           R <= p_r;
          else if (p_r.x == q_r.x)    R <= inf_point;
          else                        R <= '{inf: 1'b0, x: x3, y: y3};
          Done  <= 1'b1;
          phase <= FIN;
        end
        default: phase <= FIN;
      endcase
    end
  end

endmodule

// File: rtl/point_fifo.sv
// Small synchronous FIFO of curve points with flush; combinational head read.
module point_fifo
  import elliptic_curve_structs::*;
#(
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  curve_point_t wdata,
  output curve_point_t rdata,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  curve_point_t   mem [DEPTH];
  logic [AW:0]    wr_ptr;
  logic [AW:0]    rd_ptr;
  logic           do_push;
  logic           do_pop;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // NOTE: storage has no reset; emptiness is tracked by the pointers alone, so stale entries are never read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/msm_point_accumulator.sv
// Sums N_TERMS buffered points serially on one point_add; trivial terms (infinity, equal operands) skip the adder.
module msm_point_accumulator
  import elliptic_curve_structs::*;
#(
  parameter int N_TERMS    = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         Reset_n,
  input  logic                         start,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  curve_point_t                 in_point,
  output logic                         busy,
  output logic                         Done,
  output curve_point_t                 sum,
  output logic [$clog2(N_TERMS+1)-1:0] count,
  output logic                         err
);

  localparam int CW = $clog2(N_TERMS + 1);
  localparam logic [CW-1:0] LAST = CW'(N_TERMS - 1);
  localparam logic [CW-1:0] MAXN = CW'(N_TERMS);

  typedef enum logic [2:0] {IDLE, ACCUM, ADD_RST, ADD_WAIT, DONE} state_t;

  state_t        state;
  curve_point_t  acc;
  curve_point_t  q;
  curve_point_t  head;
  curve_point_t  add_r;
  logic [CW-1:0] accepted;
  logic          add_rst;
  logic          add_done;
  logic          fifo_full;
  logic          fifo_empty;
  logic          push;
  logic          pop;
  logic          restart;
  logic          shortcut;
  logic          term_done;
  logic          last_term;

  assign restart   = start && (state == IDLE || state == DONE);
  assign in_ready  = !fifo_full && (accepted < MAXN) &&
                     (state == ACCUM || state == ADD_RST || state == ADD_WAIT);
  assign push      = in_valid && in_ready;
  assign pop       = (state == ACCUM) && !fifo_empty;
  assign shortcut  = pop && (point_eq(acc, inf_point) || point_eq(head, inf_point) || point_eq(head, acc));
  assign term_done = shortcut || (state == ADD_WAIT && add_done);
  assign last_term = term_done && (count == LAST);
  assign sum       = acc;

  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state    <= IDLE;
      acc      <= inf_point;
      q        <= inf_point;
      count    <= '0;
      accepted <= '0;
      add_rst  <= 1'b1;
      Done     <= 1'b0;
      busy     <= 1'b0;
      err      <= 1'b0;
    end else begin
      add_rst <= 1'b0;
      if (push) accepted <= accepted + CW'(1);
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state    <= ACCUM;
            acc      <= inf_point;
            count    <= '0;
            accepted <= '0;
            Done     <= 1'b0;
            err      <= 1'b0;
            busy     <= 1'b1;
          end
        end
        ACCUM: begin
          if (pop) begin
            if (point_eq(acc, inf_point))       acc <= head;
            else if (point_eq(head, inf_point)) acc <= acc;
            else if (point_eq(head, acc))       err <= 1'b1;
            else begin
              q       <= head;
              add_rst <= 1'b1;
              state   <= ADD_RST;
            end
          end
        end
        ADD_RST:  state <= ADD_WAIT;
        ADD_WAIT: begin
          if (add_done) begin
            acc   <= add_r;
            state <= ACCUM;
          end
        end
        default: state <= IDLE;
      endcase
      // NOTE: non-blocking assignments make the later write win, so the
      // completion branch below overrides the state chosen inside the case.
      if (term_done) begin
        count <= count + CW'(1);
        if (last_term) begin
          state <= DONE;
          Done  <= 1'b1;
          busy  <= 1'b0;
        end
      end
    end
  end

  point_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (Reset_n),
    .flush (restart),
    .push  (push),
    .pop   (pop),
    .wdata (in_point),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  point_add u_add (
    .clk   (clk),
    .Reset (add_rst),
    .P     (acc),
    .Q     (q),
    .R     (add_r),
    .Done  (add_done)
  );

endmodule

// File: tb/tb_msm_point_accumulator.sv
// Directed bench for msm_point_accumulator; expected sums come from a software model of k*G on y^2 = x^3 + b.
module tb_msm_point_accumulator;
  import elliptic_curve_structs::*;

  localparam int     N_TERMS    = 4;
  localparam int     FIFO_DEPTH = 4;
  localparam int     CW         = $clog2(N_TERMS + 1);
  localparam longint PM         = 65521;
  localparam curve_point_t GP   = '{inf: 1'b0, x: 16'd3, y: 16'd7};

  logic          clk;
  logic          Reset_n;
  logic          start;
  logic          in_valid;
  logic          in_ready;
  curve_point_t  in_point;
  logic          busy;
  logic          Done;
  curve_point_t  sum;
  logic [CW-1:0] count;
  logic          err;

  int            n_cmp      = 0;
  int            n_fail     = 0;
  int            add_pulses = 0;
  curve_point_t  pts [6];

  msm_point_accumulator #(.N_TERMS(N_TERMS), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk      (clk),
    .Reset_n  (Reset_n),
    .start    (start),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_point (in_point),
    .busy     (busy),
    .Done     (Done),
    .sum      (sum),
    .count    (count),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (Reset_n && dut.add_rst) add_pulses++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic longint md(input longint a);
    return ((a % PM) + PM) % PM;
  endfunction

  function automatic longint powm(input longint b, input longint e);
    longint r  = 1;
    longint bb = md(b);
    longint ee = e;
    while (ee > 0) begin
      if ((ee & 1) != 0) r = md(r * bb);
      bb = md(bb * bb);
      ee = ee >> 1;
    end
    return r;
  endfunction

  function automatic curve_point_t ec_add(input curve_point_t a, input curve_point_t b);
    longint x1, y1, x2, y2, lam, x3, y3;
    curve_point_t r;
    if (a.inf) return b;
    if (b.inf) return a;
    x1 = longint'(a.x); y1 = longint'(a.y);
    x2 = longint'(b.x); y2 = longint'(b.y);
    if (x1 == x2) begin
      if (md(y1 + y2) == 0) return inf_point;
      lam = md(md(3 * x1 * x1) * powm(2 * y1, PM - 2));
    end else begin
      lam = md(md(y2 - y1) * powm(x2 - x1, PM - 2));
    end
    x3 = md(lam * lam - x1 - x2);
    y3 = md(lam * (x1 - x3) - y1);
    r.inf = 1'b0;
    r.x   = 16'(x3);
    r.y   = 16'(y3);
    return r;
  endfunction

  function automatic curve_point_t kmul(input int k);
    curve_point_t r = inf_point;
    for (int i = 0; i < k; i++) r = ec_add(r, GP);
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    Reset_n  = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_point = inf_point;
    repeat (2) @(posedge clk);
    #1 Reset_n = 1'b1;
    step();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic feed(input int n, input int budget, output int got);
    int t;
    got = 0;
    t   = 0;
    while (got < n && t < budget) begin
      in_point = pts[got];
      in_valid = 1'b1;
      @(negedge clk);
      if (in_ready) got++;
      step();
      t++;
    end
    in_valid = 1'b0;
    in_point = inf_point;
  endtask

  task automatic wait_done(input int budget, output int cyc);
    cyc = 0;
    while (!Done && cyc < budget) begin
      step();
      cyc++;
    end
  endtask

  task automatic wait_count(input string tag, input int target, input int budget);
    int t = 0;
    while (count != CW'(target) && t < budget) begin
      step();
      t++;
    end
    check(tag, 64'(count), 64'(target));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no summary, expected bench completion");
    $fatal(1);
  end

  initial begin
    int got;
    int cyc;
    int t;

    reset_dut();
    check("rst_done",     64'(Done),     64'(0));
    check("rst_busy",     64'(busy),     64'(0));
    check("rst_err",      64'(err),      64'(0));
    check("rst_in_ready", 64'(in_ready), 64'(0));
    check("rst_count",    64'(count),    64'(0));
    check("rst_sum",      64'(sum),      64'(inf_point));

    // G + 2G + 4G + 8G, with a start pulse during an add that must be ignored
    pulse_start();
    add_pulses = 0;
    check("a_busy", 64'(busy), 64'(1));
    pts[0] = kmul(1); pts[1] = kmul(2); pts[2] = kmul(4); pts[3] = kmul(8);
    feed(4, 50, got);
    check("a_accepted",     64'(got),      64'(4));
    check("a_ready_capped", 64'(in_ready), 64'(0));
    t = 0;
    while (!dut.add_rst && t < 200) begin
      step();
      t++;
    end
    step();
    pulse_start();
    wait_done(400, cyc);
    check("a_done",     64'(Done),       64'(1));
    check("a_sum",      64'(sum),        64'(kmul(15)));
    check("a_count",    64'(count),      64'(4));
    check("a_err",      64'(err),        64'(0));
    check("a_busy_end", 64'(busy),       64'(0));
    check("a_ready_dn", 64'(in_ready),   64'(0));
    check("a_adds",     64'(add_pulses), 64'(3));
    pulse_start();
    check("a_restart_done",  64'(Done),  64'(0));
    check("a_restart_sum",   64'(sum),   64'(inf_point));
    check("a_restart_busy",  64'(busy),  64'(1));
    check("a_restart_count", 64'(count), 64'(0));

    // inf, inf, G, inf: shortcuts only, adder never reset-pulsed
    reset_dut();
    pulse_start();
    add_pulses = 0;
    pts[0] = inf_point; pts[1] = inf_point; pts[2] = kmul(1); pts[3] = inf_point;
    feed(4, 50, got);
    wait_done(50, cyc);
    check("b_done",    64'(Done),       64'(1));
    check("b_latency", 64'(cyc),        64'(1));
    check("b_sum",     64'(sum),        64'(kmul(1)));
    check("b_count",   64'(count),      64'(4));
    check("b_err",     64'(err),        64'(0));
    check("b_adds",    64'(add_pulses), 64'(0));

    // G, G, 3G, 5G: equal operands flag err and are skipped
    reset_dut();
    pulse_start();
    add_pulses = 0;
    pts[0] = kmul(1); pts[1] = kmul(1); pts[2] = kmul(3); pts[3] = kmul(5);
    fork
      feed(4, 50, got);
      begin
        wait_count("c_reach_two", 2, 50);
        check("c_err_after_two", 64'(err), 64'(1));
      end
    join
    wait_done(300, cyc);
    check("c_done",  64'(Done),       64'(1));
    check("c_sum",   64'(sum),        64'(kmul(9)));
    check("c_err",   64'(err),        64'(1));
    check("c_count", 64'(count),      64'(4));
    check("c_adds",  64'(add_pulses), 64'(2));

    // six beats offered, only four accepted, order observable through err
    reset_dut();
    pulse_start();
    add_pulses = 0;
    for (int i = 0; i < 6; i++) pts[i] = kmul(i + 1);
    feed(6, 60, got);
    check("d_accepted", 64'(got),      64'(4));
    check("d_ready",    64'(in_ready), 64'(0));
    wait_done(300, cyc);
    check("d_done",  64'(Done),       64'(1));
    check("d_sum",   64'(sum),        64'(kmul(7)));
    check("d_err",   64'(err),        64'(1));
    check("d_count", 64'(count),      64'(4));
    check("d_adds",  64'(add_pulses), 64'(2));

    // asynchronous reset during an add with two points still queued
    reset_dut();
    pulse_start();
    pts[0] = kmul(1); pts[1] = kmul(2); pts[2] = kmul(4); pts[3] = kmul(8);
    feed(4, 50, got);
    check("e_queued", 64'(dut.fifo_empty), 64'(0));
    Reset_n = 1'b0;
    #1;
    check("e_rst_done",    64'(Done),           64'(0));
    check("e_rst_busy",    64'(busy),           64'(0));
    check("e_rst_err",     64'(err),            64'(0));
    check("e_rst_ready",   64'(in_ready),       64'(0));
    check("e_rst_count",   64'(count),          64'(0));
    check("e_rst_sum",     64'(sum),            64'(inf_point));
    check("e_rst_empty",   64'(dut.fifo_empty), 64'(1));
    check("e_rst_add_rst", 64'(dut.add_rst),    64'(1));
    #2 Reset_n = 1'b1;
    step();
    pulse_start();
    pts[0] = kmul(3); pts[1] = inf_point; pts[2] = kmul(5); pts[3] = kmul(2);
    feed(4, 50, got);
    wait_done(300, cyc);
    check("e_done",  64'(Done),  64'(1));
    check("e_sum",   64'(sum),   64'(kmul(10)));
    check("e_err",   64'(err),   64'(0));
    check("e_count", 64'(count), 64'(4));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
